periph_bus_arbiter: RTL

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter_if.sv | 33 +++
 rtl/periph_bus_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter_if.sv
// Bus bundle for periph_bus_arbiter: two requester ports, the shared peripheral bus
// and the peripheral's registered read data.
interface periph_bus_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] addr;
  logic [15:0] data;
  logic        we;
  logic        en;
  logic [15:0] q;

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q,
    output ack0, ack1, rdata, busy, addr, data, we, en
  );

  // Requesters plus peripheral side.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, q,
    input  ack0, ack1, rdata, busy, addr, data, we, en
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-requester peripheral bus arbiter: IDLE -> ISSUE -> WAIT -> DONE, one transaction per 4 cycles.
// Define PERIPH_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 0.
module periph_bus_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  periph_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant_valid;
  logic        grant_sel;
  logic        owner;
  logic        we_lat;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] rdata_q;
  logic        en_c;
  logic        we_c;
  logic        ack0_c;
  logic        ack1_c;
  logic        busy_c;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

`ifdef PERIPH_ARB_ROUND_ROBIN_EN
  logic last_served;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            last_served <= 1'b1;
    else if (grant_valid) last_served <= grant_sel;
  end
`endif

  // A lone request wins outright; only a tie consults the tie-break policy.
  always_comb begin
    grant_sel = bus.req1;
    if (bus.req0 && bus.req1) begin
`ifdef PERIPH_ARB_ROUND_ROBIN_EN
      grant_sel = ~last_served;
`else
      grant_sel = 1'b0;
`endif
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    en_c        = 1'b0;
    we_c        = 1'b0;
    ack0_c      = 1'b0;
    ack1_c      = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.req0 || bus.req1) begin
          grant_valid = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        en_c      = 1'b1;
        we_c      = we_lat;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = DONE;
      DONE: begin
        ack0_c    = ~owner;
        ack1_c    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant, so later changes on reqN/addrN cannot disturb the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= 1'b0;
      we_lat  <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      if (grant_valid) begin
        owner  <= grant_sel;
        we_lat <= grant_sel ? bus.we1    : bus.we0;
        addr_q <= grant_sel ? bus.addr1  : bus.addr0;
        data_q <= grant_sel ? bus.wdata1 : bus.wdata0;
      end
      if (state == WAIT) rdata_q <= bus.q;
    end
  end

  assign bus.en    = en_c;
  assign bus.we    = we_c;
  assign bus.ack0  = ack0_c;
  assign bus.ack1  = ack1_c;
  assign bus.busy  = busy_c;
  assign bus.addr  = addr_q;
  assign bus.data  = data_q;
  assign bus.rdata = rdata_q;

endmodule
